// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the parametrised UART receive path: FSM states,
// parity mode constants and the majority-vote helper.
package uart_rx_frame_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_frame_bit_sampler.sv
// Line synchroniser, start-edge detector, per-bit timer and 3-sample majority
// vote around the bit centre.
module uart_rx_frame_bit_sampler
    import uart_rx_frame_pkg::*;
#(
    parameter int WAIT_CYCLES = 234
) (
    input  logic clk,
    input  logic btn,
    input  logic uart_rx,
    input  logic idle,
    input  logic running,
    output logic line_sync,
    output logic start_edge,
    output logic bit_valid,
    output logic bit_val,
    output logic bit_end
);

    localparam int CNT_W = $clog2(WAIT_CYCLES);
    localparam int HALF  = WAIT_CYCLES / 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(HALF + 1);

    logic             sync1;
    logic             sync2;
    logic             line_prev;
    logic [1:0]       settle;
    logic [CNT_W-1:0] count;
    logic             samp_a;
    logic             samp_b;

    // line_prev only tracks real pin data once the synchroniser has flushed its
    // reset value, so a line that is already low at reset release never looks
    // like a falling edge.
    always_ff @(posedge clk or negedge btn) begin
        if (!btn) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            settle    <= 2'd0;
            line_prev <= 1'b0;
        end else begin
            sync1     <= uart_rx;
            sync2     <= sync1;
            if (settle != 2'd2)
                settle <= settle + 2'd1;
            line_prev <= (settle == 2'd2) & sync2;
        end
    end

    // The start-edge cycle is count 0, so the counter loads 1 on the following edge.
    always_ff @(posedge clk or negedge btn) begin
        if (!btn) begin
            count  <= '0;
            samp_a <= 1'b0;
            samp_b <= 1'b0;
        end else begin
            if (idle)
                count <= start_edge ? CNT_W'(1) : '0;
            else if (running)
                count <= (count == CNT_LAST) ? '0 : count + CNT_W'(1);
            else
                count <= '0;
            if (count == SAMP_A)
                samp_a <= sync2;
            if (count == SAMP_B)
                samp_b <= sync2;
        end
    end

    assign line_sync  = sync2;
    assign start_edge = line_prev & ~sync2;
    assign bit_valid  = running && (count == SAMP_C);
    assign bit_val    = majority3(samp_a, samp_b, sync2);
    assign bit_end    = running && (count == CNT_LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: frame FSM, shift register, parity/stop/break
// checks and a one-entry valid/ready holding register with overrun flag.
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int WAIT_CYCLES = 234,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 btn,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam logic [3:0] LAST_IDX  = 4'(DATA_BITS - 1);
    localparam logic       STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    rx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic                 par_bit;
    logic                 ferr_acc;

    logic line_sync;
    logic start_edge;
    logic bit_valid;
    logic bit_val;
    logic bit_end;
    logic frame_done;
    logic frame_ferr;
    logic frame_perr;
    logic is_break;
    logic accept;

    uart_rx_frame_bit_sampler #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_sampler (
        .clk       (clk),
        .btn       (btn),
        .uart_rx   (uart_rx),
        .idle      (state == ST_IDLE),
        .running   ((state != ST_IDLE) && (state != ST_BRK)),
        .line_sync (line_sync),
        .start_edge(start_edge),
        .bit_valid (bit_valid),
        .bit_val   (bit_val),
        .bit_end   (bit_end)
    );

    assign frame_done = (state == ST_STOP) && bit_valid && (stop_idx == STOP_LAST);
    assign frame_ferr = ferr_acc | ~bit_val;
    assign is_break   = (shreg == '0) && !par_bit && frame_ferr;
    assign accept     = rx_valid & rx_ready;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        frame_perr = 1'b0;
        case (PARITY_MODE)
            PARITY_ODD:  frame_perr = ~(^shreg ^ par_bit);
            PARITY_EVEN: frame_perr = ^shreg ^ par_bit;
            default:     frame_perr = 1'b0;
        endcase
    end

    // Frame sequencer; the last stop bit returns to IDLE at its decision point
    // so a back-to-back start edge half a bit later is still caught.
    always_ff @(posedge clk or negedge btn) begin
        if (!btn) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_idx   <= 4'd0;
            stop_idx  <= 1'b0;
            par_bit   <= 1'b0;
            ferr_acc  <= 1'b0;
            break_det <= 1'b0;
        end else begin
            break_det <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state    <= ST_START;
                        bit_idx  <= 4'd0;
                        stop_idx <= 1'b0;
                        par_bit  <= 1'b0;
                        ferr_acc <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_valid && bit_val)
                        state <= ST_IDLE;
                    else if (bit_end)
                        state <= ST_DATA;
                end
                ST_DATA: begin
                    if (bit_valid)
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (bit_idx == LAST_IDX)
                            state <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        else
                            bit_idx <= bit_idx + 4'd1;
                    end
                end
                ST_PARITY: begin
                    if (bit_valid)
                        par_bit <= bit_val;
                    if (bit_end)
                        state <= ST_STOP;
                end
                ST_STOP: begin
                    if (bit_valid) begin
                        ferr_acc <= ferr_acc | ~bit_val;
                        if (stop_idx == STOP_LAST) begin
                            if (is_break) begin
                                state     <= ST_BRK;
                                break_det <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end else if (bit_end) begin
                        stop_idx <= stop_idx + 1'b1;
                    end
                end
                ST_BRK: begin
                    if (line_sync)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A completed frame replaces the held word only if the slot is free or is
    // being consumed in the same cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk or negedge btn) begin
        if (!btn) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (frame_done && (!rx_valid || accept)) begin
                rx_data  <= shreg;
                rx_perr  <= frame_perr;
                rx_ferr  <= frame_ferr;
                rx_valid <= 1'b1;
            end else if (accept) begin
                rx_valid <= 1'b0;
            end
            if (accept)
                overrun <= 1'b0;
            else if (frame_done && rx_valid)
                overrun <= 1'b1;
        end
    end

endmodule
